// File: rtl/watch_pkg.sv
// Shared constants and types for the watch button front end.
// Default timing assumes a 50 MHz system clock.
package watch_pkg;

   localparam int N_BTN     = 6;
   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_LEFT  = 2;
   localparam int BTN_RIGHT = 3;
   localparam int BTN_ENTER = 4;
   localparam int BTN_ESC   = 5;

   // 10 ms debounce, 0.5 s first repeat, 0.1 s repeat period at 50 MHz
   localparam int DEF_DEBOUNCE_CYCLES = 500_000;
   localparam int DEF_REPEAT_DELAY    = 25_000_000;
   localparam int DEF_REPEAT_PERIOD   = 5_000_000;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      REPEAT
   } rpt_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_cond_if.sv
// Button pads in, conditioned per-button events out.
// The master modport is the conditioner; the slave is its consumer.
interface button_cond_if #(
   parameter int N_BTN = watch_pkg::N_BTN
);
   logic [N_BTN-1:0] btn_i;
   logic [N_BTN-1:0] held_o;
   logic [N_BTN-1:0] press_o;
   logic [N_BTN-1:0] release_o;
   logic [N_BTN-1:0] rpt_o;
   logic [N_BTN-1:0] long_o;

   modport master (
      input  btn_i,
      output held_o, press_o, release_o, rpt_o, long_o
   );

   modport slave (
      output btn_i,
      input  held_o, press_o, release_o, rpt_o, long_o
   );
endinterface

// File: rtl/btn_chan.sv
// One button channel: 2-flop synchronizer, debounce counter, edge pulses
// and the auto-repeat FSM. All outputs are registered.
module btn_chan
   import watch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic pad,
   output logic held,
   output logic press,
   output logic release_pulse,
   output logic rpt,
   output logic long_hold
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [DW-1:0] D_LAST     = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PER_LAST   = RW'(REPEAT_PERIOD - 1);
   // Raw pad level meaning "not pressed"; a button held through reset
   // then shows up as a fresh press once the synchronizer fills.
   localparam logic PAD_IDLE = ACTIVE_LOW;

   logic          sync1, sync2, s;
   logic [DW-1:0] dcnt;
   logic          flip, rise_ev, fall_ev;
   rpt_state_t    state;
   logic [RW-1:0] rcnt;

   // NOTE: every clocked block uses non-blocking assignments so that all
   // flops sample the pre-edge values of each other, matching real hardware.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= PAD_IDLE;
         sync2 <= PAD_IDLE;
      end else begin
         sync1 <= pad;
         sync2 <= sync1;
      end
   end

   assign s       = ACTIVE_LOW ? ~sync2 : sync2;
   assign flip    = (s != held) && (dcnt == D_LAST);
   assign rise_ev = flip && !held;
   assign fall_ev = flip && held;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dcnt          <= '0;
         held          <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press         <= rise_ev;
         release_pulse <= fall_ev;
         if (s == held) begin
            dcnt <= '0;
         end else if (dcnt == D_LAST) begin
            dcnt <= '0;
            held <= ~held;
         end else begin
            dcnt <= dcnt + DW'(1);
         end
      end
   end

   // Release wins over a coincident repeat tick, so no pulse on the way out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rcnt      <= '0;
         rpt       <= 1'b0;
         long_hold <= 1'b0;
      end else begin
         rpt <= 1'b0;
         case (state)
            IDLE: begin
               if (rise_ev) begin
                  rpt   <= 1'b1;
                  rcnt  <= '0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (fall_ev) begin
                  long_hold <= 1'b0;
                  state     <= IDLE;
               end else if (rcnt == DELAY_LAST) begin
                  rpt       <= 1'b1;
                  long_hold <= 1'b1;
                  rcnt      <= '0;
                  state     <= REPEAT;
               end else begin
                  rcnt <= rcnt + RW'(1);
               end
            end
            REPEAT: begin
               if (fall_ev) begin
                  long_hold <= 1'b0;
                  state     <= IDLE;
               end else if (rcnt == PER_LAST) begin
                  rpt  <= 1'b1;
                  rcnt <= '0;
               end else begin
                  rcnt <= rcnt + RW'(1);
               end
            end
            default: begin
               long_hold <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/button_cond.sv
// Conditions the watch's push buttons: one independent btn_chan per button,
// no priority or masking between channels.
module button_cond #(
   parameter int N_BTN           = watch_pkg::N_BTN,
   parameter int DEBOUNCE_CYCLES = watch_pkg::DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = watch_pkg::DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = watch_pkg::DEF_REPEAT_PERIOD,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   button_cond_if.master bus
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      btn_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_chan (
         .clk           (clk),
         .rst           (rst),
         .pad           (bus.btn_i[i]),
         .held          (bus.held_o[i]),
         .press         (bus.press_o[i]),
         .release_pulse (bus.release_o[i]),
         .rpt           (bus.rpt_o[i]),
         .long_hold     (bus.long_o[i])
      );
   end

endmodule

// File: tb/tb_button_cond.sv
// Scoreboard bench for button_cond with short timing (debounce 4, delay 10,
// period 3). Expected events are queued by cycle; the monitor matches them.
module tb_button_cond;

   typedef enum logic [2:0] {
      EV_PRESS, EV_RELEASE, EV_RPT, EV_LONG_UP, EV_LONG_DN
   } ev_kind_t;

   typedef struct packed {
      ev_kind_t    kind;
      logic [5:0]  bits;
      logic [22:0] cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   ev_t  exp_q[$];
   logic [5:0] long_q = '0;

   button_cond_if #(.N_BTN(6)) bus ();

   button_cond #(
      .N_BTN           (6),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (3),
      .ACTIVE_LOW      (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input ev_kind_t k, input logic [5:0] b, input int c);
      ev_t e;
      e.kind = k;
      e.bits = b;
      e.cyc  = 23'(c);
      exp_q.push_back(e);
   endtask

   task automatic observe(input ev_kind_t k, input logic [5:0] v);
      ev_t act;
      if (v != 6'h00) begin
         act.kind = k;
         act.bits = v;
         act.cyc  = 23'(cyc);
         if (exp_q.size() == 0) check("unexpected event", act, 32'h0);
         else                   check("event", act, exp_q.pop_front());
      end
   endtask

   // Monitor: flush overdue expectations, then match observed events in a
   // fixed per-cycle order (press, release, rpt, long up, long down).
   always @(negedge clk) begin
      while (exp_q.size() > 0 && int'(exp_q[0].cyc) < cyc)
         check("missing event", 32'h0, exp_q.pop_front());
      observe(EV_PRESS,   bus.press_o);
      observe(EV_RELEASE, bus.release_o);
      observe(EV_RPT,     bus.rpt_o);
      observe(EV_LONG_UP, bus.long_o & ~long_q);
      observe(EV_LONG_DN, ~bus.long_o & long_q);
      long_q <= bus.long_o;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic all_zero(input string name);
      check(name, {2'b00, bus.held_o, bus.press_o, bus.release_o, bus.rpt_o, bus.long_o}, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int t;
      int p;
      bus.btn_i = 6'h00;

      // Reset with all pads pressed: silent during reset, fresh press after.
      step(3);
      all_zero("reset outputs");
      step(1);
      t = cyc;
      rst = 1'b0;
      expect_ev(EV_PRESS, 6'h3F, t + 6);
      expect_ev(EV_RPT,   6'h3F, t + 6);
      expect_ev(EV_RELEASE, 6'h3F, t + 13);
      step(7);
      check("held after reset", 32'(bus.held_o), 32'h3F);
      bus.btn_i = 6'h3F;
      step(15);
      all_zero("idle after reset test");

      // Clean short press on up.
      t = cyc;
      bus.btn_i[0] = 1'b0;
      expect_ev(EV_PRESS,   6'h01, t + 6);
      expect_ev(EV_RPT,     6'h01, t + 6);
      expect_ev(EV_RELEASE, 6'h01, t + 14);
      step(8);
      bus.btn_i[0] = 1'b1;
      step(2);
      check("held up", 32'(bus.held_o), 32'h01);
      step(15);

      // Glitchy enter: never stable for 4 cycles.
      bus.btn_i[4] = 1'b0;
      step(3);
      bus.btn_i[4] = 1'b1;
      step(1);
      bus.btn_i[4] = 1'b0;
      step(3);
      bus.btn_i[4] = 1'b1;
      step(2);
      check("glitch held", 32'(bus.held_o), 32'h0);
      step(10);

      // Long hold on down: repeats at +0, +10, then every 3.
      t = cyc;
      p = t + 6;
      bus.btn_i[1] = 1'b0;
      expect_ev(EV_PRESS, 6'h02, p);
      expect_ev(EV_RPT,   6'h02, p);
      expect_ev(EV_RPT,     6'h02, p + 10);
      expect_ev(EV_LONG_UP, 6'h02, p + 10);
      for (int k = 13; k <= 34; k += 3) expect_ev(EV_RPT, 6'h02, p + k);
      expect_ev(EV_RELEASE, 6'h02, p + 36);
      expect_ev(EV_LONG_DN, 6'h02, p + 36);
      step(36);
      bus.btn_i[1] = 1'b1;
      step(12);
      check("long after release", 32'(bus.long_o | bus.held_o), 32'h0);
      step(5);

      // Right: debounced release lands exactly on a repeat tick.
      t = cyc;
      p = t + 6;
      bus.btn_i[3] = 1'b0;
      expect_ev(EV_PRESS, 6'h08, p);
      expect_ev(EV_RPT,   6'h08, p);
      expect_ev(EV_RPT,     6'h08, p + 10);
      expect_ev(EV_LONG_UP, 6'h08, p + 10);
      for (int k = 13; k <= 34; k += 3) expect_ev(EV_RPT, 6'h08, p + k);
      expect_ev(EV_RELEASE, 6'h08, p + 37);
      expect_ev(EV_LONG_DN, 6'h08, p + 37);
      step(37);
      bus.btn_i[3] = 1'b1;
      step(6);
      check("tick vs release rpt", 32'(bus.rpt_o), 32'h0);
      step(8);

      // Left and esc together, then async reset mid-hold.
      t = cyc;
      bus.btn_i = 6'h1B;
      expect_ev(EV_PRESS, 6'h24, t + 6);
      expect_ev(EV_RPT,   6'h24, t + 6);
      step(8);
      check("chord held", 32'(bus.held_o), 32'h24);
      #2 rst = 1'b1;
      #1 all_zero("async reset mid-hold");
      bus.btn_i = 6'h3F;
      step(3);
      rst = 1'b0;
      step(20);
      all_zero("idle after reset");

      check("scoreboard drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
